ccff_loader: RTL and testbench



---
 rtl/ccff_loader.sv | 171 +++++++++++++++++
 tb/tb_ccff_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_loader.sv
// ccff_loader: accepts configuration words over valid/ready and shifts CHAIN_LEN bits
// MSB-first onto a config flip-flop chain. CCFF_LOADER_CRC_EN adds a CRC-16-CCITT output.
module ccff_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 48
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              cfg_start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              cfg_busy,
  output logic              cfg_done
`ifdef CCFF_LOADER_CRC_EN
  ,
  output logic [15:0]       cfg_crc
`endif
);

  localparam int BIT_W  = $clog2(CHAIN_LEN + 1);
  localparam int WBIT_W = $clog2(WORD_W);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(CHAIN_LEN - 1);
  localparam logic [WBIT_W-1:0] LAST_WBIT = WBIT_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } state_e;

  state_e            state_q,    state_d;
  logic [WORD_W-1:0] shreg_q,    shreg_d;
  logic [BIT_W-1:0]  bitcnt_q,   bitcnt_d;
  logic [WBIT_W-1:0] wbit_q,     wbit_d;
  logic              ready_q,    ready_d;
  logic              head_q,     head_d;
  logic              shift_en_q, shift_en_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;

`ifdef CCFF_LOADER_CRC_EN
  logic [15:0]       crc_q,      crc_d;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction
`endif

  // Outputs are computed one cycle ahead so the bit shown on ccff_head is the
  // one whose index bitcnt_q/wbit_q currently hold; the shift register keeps
  // only the bits still to be shown.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    wbit_d     = wbit_q;
    ready_d    = ready_q;
    head_d     = head_q;
    shift_en_d = shift_en_q;
    busy_d     = busy_q;
    done_d     = done_q;
`ifdef CCFF_LOADER_CRC_EN
    crc_d      = crc_q;
    if (shift_en_q) begin
      crc_d = crc_step(crc_q, head_q);
    end
`endif

    case (state_q)
      IDLE, DONE: begin
        if (cfg_start) begin
          state_d  = FETCH;
          bitcnt_d = '0;
          done_d   = 1'b0;
          ready_d  = 1'b1;
          busy_d   = 1'b1;
`ifdef CCFF_LOADER_CRC_EN
          crc_d    = 16'hFFFF;
`endif
        end
      end

      FETCH: begin
        if (cfg_valid) begin
          state_d    = SHIFT;
          shreg_d    = cfg_data << 1;
          wbit_d     = '0;
          head_d     = cfg_data[WORD_W-1];
          shift_en_d = 1'b1;
          ready_d    = 1'b0;
        end
      end

      SHIFT: begin
        bitcnt_d = bitcnt_q + BIT_W'(1);
        wbit_d   = wbit_q + WBIT_W'(1);
        // Chain length ends the load even mid-word; leftover word bits are dropped.
        if (bitcnt_q == LAST_BIT) begin
          state_d    = DONE;
          shift_en_d = 1'b0;
          head_d     = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else if (wbit_q == LAST_WBIT) begin
          state_d    = FETCH;
          shift_en_d = 1'b0;
          head_d     = 1'b0;
          ready_d    = 1'b1;
        end else begin
          head_d  = shreg_q[WORD_W-1];
          shreg_d = shreg_q << 1;
        end
      end

      default: begin
        state_d    = IDLE;
        ready_d    = 1'b0;
        head_d     = 1'b0;
        shift_en_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      wbit_q     <= '0;
      ready_q    <= 1'b0;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef CCFF_LOADER_CRC_EN
      crc_q      <= 16'hFFFF;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      wbit_q     <= wbit_d;
      ready_q    <= ready_d;
      head_q     <= head_d;
      shift_en_q <= shift_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef CCFF_LOADER_CRC_EN
      crc_q      <= crc_d;
`endif
    end
  end

  assign cfg_ready     = ready_q;
  assign ccff_head     = head_q;
  assign ccff_shift_en = shift_en_q;
  assign cfg_busy      = busy_q;
  assign cfg_done      = done_q;
`ifdef CCFF_LOADER_CRC_EN
  assign cfg_crc       = crc_q;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Self-checking bench for ccff_loader: default 48-bit chain instance plus a CHAIN_LEN=1 instance.
// Head bits are queued as words are offered and popped as the chain shifts.
module tb_ccff_loader;

  logic        prog_clk;
  logic        pReset_n;
  logic        cfg_start;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        ccff_head;
  logic        ccff_shift_en;
  logic        cfg_busy;
  logic        cfg_done;

  logic        start1;
  logic [31:0] data1;
  logic        valid1;
  logic        ready1;
  logic        head1;
  logic        shift_en1;
  logic        busy1;
  logic        done1;

`ifdef CCFF_LOADER_CRC_EN
  logic [15:0] cfg_crc;
  logic [15:0] crc1;
`endif

  ccff_loader #(.WORD_W(32), .CHAIN_LEN(48)) dut (
    .prog_clk      (prog_clk),
    .pReset_n      (pReset_n),
    .cfg_start     (cfg_start),
    .cfg_data      (cfg_data),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .cfg_busy      (cfg_busy),
    .cfg_done      (cfg_done)
`ifdef CCFF_LOADER_CRC_EN
    ,
    .cfg_crc       (cfg_crc)
`endif
  );

  ccff_loader #(.WORD_W(32), .CHAIN_LEN(1)) dut1 (
    .prog_clk      (prog_clk),
    .pReset_n      (pReset_n),
    .cfg_start     (start1),
    .cfg_data      (data1),
    .cfg_valid     (valid1),
    .cfg_ready     (ready1),
    .ccff_head     (head1),
    .ccff_shift_en (shift_en1),
    .cfg_busy      (busy1),
    .cfg_done      (done1)
`ifdef CCFF_LOADER_CRC_EN
    ,
    .cfg_crc       (crc1)
`endif
  );

  int   pass_cnt  = 0;
  int   fail_cnt  = 0;
  int   total_cnt = 0;
  int   cyc       = 0;
  int   shift_cnt;
  int   first_shift;
  int   last_shift;
  int   done_cyc;
  int   t0;
  logic exp_q[$];

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  always @(posedge prog_clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic b);
    logic [15:0] r;
    r = {c[14:0], 1'b0};
    if (c[15] != b) r = r ^ 16'h1021;
    return r;
  endfunction

  // Scoreboard side: every shift pulse of the 48-bit instance consumes one expected bit.
  always @(negedge prog_clk) begin
    if (ccff_shift_en === 1'b1) begin
      shift_cnt++;
      if (first_shift < 0) first_shift = cyc;
      last_shift = cyc;
      if (exp_q.size() == 0) begin
        check_output("extra_shift", 32'(ccff_shift_en), 32'h0);
      end else begin
        check_output("ccff_head", 32'(ccff_head), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic run_load(input logic [31:0] w0, input logic [31:0] w1, input int stall_cycles,
                          input int restart_at, input int reset_at);
    int  idx;
    int  stalled;
    bit  restarted;
    bit  accepted;
    bit  finished;
    shift_cnt   = 0;
    first_shift = -1;
    last_shift  = -1;
    done_cyc    = -1;
    exp_q.delete();
    for (int i = 31; i >= 0; i--) exp_q.push_back(w0[i]);
    for (int i = 31; i >= 16; i--) exp_q.push_back(w1[i]);
    idx       = 0;
    stalled   = 0;
    restarted = 0;
    finished  = 0;
    cfg_data  = w0;
    cfg_valid = 1'b1;
    cfg_start = 1'b1;
    t0        = cyc;
    step();
    cfg_start = 1'b0;
    check_output("ready_at_t1", 32'(cfg_ready), 32'h1);
    check_output("busy_at_t1", 32'(cfg_busy), 32'h1);
`ifdef CCFF_LOADER_CRC_EN
    check_output("crc_after_start", 32'(cfg_crc), 32'hFFFF);
`endif
    for (int n = 0; n < 400; n++) begin
      if (cfg_done === 1'b1) begin
        done_cyc = cyc;
        finished = 1;
        break;
      end
      if (reset_at > 0 && ccff_shift_en === 1'b1 && shift_cnt == reset_at - 1) begin
        pReset_n = 1'b0;
        #1;
        check_output("rst_ready", 32'(cfg_ready), 32'h0);
        check_output("rst_head", 32'(ccff_head), 32'h0);
        check_output("rst_shift_en", 32'(ccff_shift_en), 32'h0);
        check_output("rst_busy", 32'(cfg_busy), 32'h0);
        check_output("rst_done", 32'(cfg_done), 32'h0);
`ifdef CCFF_LOADER_CRC_EN
        check_output("rst_crc", 32'(cfg_crc), 32'hFFFF);
`endif
        finished = 1;
        break;
      end
      cfg_start = 1'b0;
      if (restart_at > 0 && !restarted && shift_cnt == restart_at) begin
        cfg_start = 1'b1;
        restarted = 1;
      end
      if (cfg_ready === 1'b1 && idx == 1 && stalled < stall_cycles) begin
        cfg_valid = 1'b0;
        stalled++;
        check_output("stall_shift_en", 32'(ccff_shift_en), 32'h0);
        check_output("stall_busy", 32'(cfg_busy), 32'h1);
      end else begin
        cfg_valid = 1'b1;
      end
      accepted = (cfg_ready === 1'b1) && (cfg_valid === 1'b1);
      step();
      if (accepted) begin
        idx++;
        cfg_data = w1;
      end
    end
    cfg_start = 1'b0;
    if (!finished) check_output("load_timeout", 32'h0, 32'h1);
  endtask

  task automatic check_timing(input int extra);
    check_output("first_shift_cyc", 32'(first_shift - t0), 32'd2);
    check_output("last_shift_cyc", 32'(last_shift - t0), 32'(50 + extra));
    check_output("shift_count", 32'(shift_cnt), 32'd48);
    check_output("done_cyc", 32'(done_cyc - t0), 32'(51 + extra));
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    check_output("busy_at_done", 32'(cfg_busy), 32'h0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [15:0] crc_exp;
    int          pulses;
    pReset_n  = 1'b0;
    cfg_start = 1'b0;
    cfg_data  = '0;
    cfg_valid = 1'b0;
    start1    = 1'b0;
    data1     = '0;
    valid1    = 1'b0;
    shift_cnt = 0;
    first_shift = -1;
    last_shift  = -1;
    step();
    step();
    check_output("reset_ready", 32'(cfg_ready), 32'h0);
    check_output("reset_head", 32'(ccff_head), 32'h0);
    check_output("reset_shift_en", 32'(ccff_shift_en), 32'h0);
    check_output("reset_busy", 32'(cfg_busy), 32'h0);
    check_output("reset_done", 32'(cfg_done), 32'h0);
`ifdef CCFF_LOADER_CRC_EN
    check_output("reset_crc", 32'(cfg_crc), 32'hFFFF);
`endif
    pReset_n = 1'b1;
    step();

    $display("[TB] basic two-word load");
    run_load(32'hA5A50F0F, 32'h1234FFFF, 0, 0, 0);
    check_timing(0);
    step();
    step();
    check_output("done_held", 32'(cfg_done), 32'h1);
    check_output("no_more_shifts", 32'(shift_cnt), 32'd48);

    $display("[TB] 10-cycle stall in second fetch");
    run_load(32'h0F0F1234, 32'hC3C3AAAA, 10, 0, 0);
    check_timing(10);

    $display("[TB] start pulse during shift is ignored");
    run_load(32'hDEADBEEF, 32'h80010000, 0, 10, 0);
    check_timing(0);

    $display("[TB] reset at 20th shift cycle");
    run_load(32'hFFFFFFFF, 32'hFFFF0000, 0, 0, 20);
    check_output("rst_shift_count", 32'(shift_cnt), 32'd19);
    step();
    step();
    pReset_n = 1'b1;
    step();
    run_load(32'h13579BDF, 32'h2468ACE0, 0, 0, 0);
    check_timing(0);

    $display("[TB] CHAIN_LEN=1 instance");
    data1  = 32'h80000000;
    valid1 = 1'b1;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    check_output("c1_ready_t1", 32'(ready1), 32'h1);
    check_output("c1_shift_t1", 32'(shift_en1), 32'h0);
    step();
    check_output("c1_shift_t2", 32'(shift_en1), 32'h1);
    check_output("c1_head_t2", 32'(head1), 32'h1);
    check_output("c1_ready_t2", 32'(ready1), 32'h0);
    step();
    check_output("c1_done_t3", 32'(done1), 32'h1);
    check_output("c1_shift_t3", 32'(shift_en1), 32'h0);
    check_output("c1_busy_t3", 32'(busy1), 32'h0);
`ifdef CCFF_LOADER_CRC_EN
    check_output("c1_crc", 32'(crc1), 32'(crc_ref(16'hFFFF, 1'b1)));
`endif
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (shift_en1 === 1'b1 || ready1 === 1'b1) pulses++;
      step();
    end
    check_output("c1_quiet_after", 32'(pulses), 32'd0);
    valid1 = 1'b0;

`ifdef CCFF_LOADER_CRC_EN
    $display("[TB] random CRC loads");
    for (int it = 0; it < 100; it++) begin
      ra = $urandom;
      rb = $urandom;
      crc_exp = 16'hFFFF;
      for (int i = 31; i >= 0; i--) crc_exp = crc_ref(crc_exp, ra[i]);
      for (int i = 31; i >= 16; i--) crc_exp = crc_ref(crc_exp, rb[i]);
      run_load(ra, rb, 0, 0, 0);
      check_output("crc_at_done", 32'(cfg_crc), 32'(crc_exp));
      check_output("crc_shift_count", 32'(shift_cnt), 32'd48);
    end
`else
    ra = 32'h0;
    rb = 32'h0;
    crc_exp = 16'h0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
